alu4bit_cmd_sequencer: RTL and testbench

//  Synthesizable command front-end for the combinational 4-bit ALU (alu4bit).

---
 rtl/alu4bit_cmd_sequencer_pkg.sv | 15 +
 rtl/alu4bit_cmd_sequencer_fifo.sv | 56 +++++
 rtl/alu4bit_cmd_sequencer.sv | 118 +++++++++++
 tb/tb_alu4bit_cmd_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu4bit_cmd_sequencer_pkg.sv
// Shared types and default widths for the 4-bit ALU command sequencer.
package alu4bit_cmd_sequencer_pkg;

   localparam int DEF_DATA_W     = 4;
   localparam int DEF_OP_W       = 3;
   localparam int DEF_SEQ_W      = 4;
   localparam int DEF_SETTLE_CYC = 1;
   localparam int DEF_FIFO_DEPTH = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRIVE = 1'b1
   } seq_state_e;

endpackage

// File: rtl/alu4bit_cmd_sequencer_fifo.sv
// Synchronous show-ahead response FIFO; head entry is visible while not empty.
module alu_rsp_fifo
   import alu4bit_cmd_sequencer_pkg::*;
#(
   parameter int WIDTH = DEF_DATA_W + DEF_OP_W + DEF_SEQ_W,
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rd_data = mem[rd_ptr];

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   // Pointer and occupancy bookkeeping; push+pop together leaves count alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alu4bit_cmd_sequencer.sv
// Command front-end for the combinational 4-bit ALU: accepts a command, holds it
// on the ALU for SETTLE_CYC cycles, samples the result and queues a tagged response.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | no command in flight; ready when response FIFO has room
//   ST_DRIVE | operands on ALU, settle counter running; sample at zero
module alu4bit_cmd_sequencer
   import alu4bit_cmd_sequencer_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int OP_W       = DEF_OP_W,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int SEQ_W      = DEF_SEQ_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic [OP_W-1:0]   cmd_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_op_sel,
   input  logic [DATA_W-1:0] alu_result,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [OP_W-1:0]   rsp_op,
   output logic [SEQ_W-1:0]  rsp_seq,
   output logic              busy
);

   localparam int                    RSP_W       = DATA_W + OP_W + SEQ_W;
   localparam int                    CNT_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CNT_W-1:0]      SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
   localparam int                    FCNT_W      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [FCNT_W-1:0]     FIFO_FULL   = FIFO_DEPTH[FCNT_W-1:0];

   seq_state_e        state_q;
   seq_state_e        state_d;
   logic [CNT_W-1:0]  settle_cnt_q;
   logic [SEQ_W-1:0]  seq_q;
   logic [SEQ_W-1:0]  tag_q;
   logic              accept;
   logic              settle_done;
   logic              fifo_full;
   logic              fifo_empty;
   logic [FCNT_W-1:0] fifo_count;
   logic [RSP_W-1:0]  fifo_rd_data;

   assign cmd_ready   = (state_q == ST_IDLE) & ~fifo_full;
   assign accept      = cmd_valid & cmd_ready;
   assign settle_done = (state_q == ST_DRIVE) && (settle_cnt_q == '0);
   assign busy        = (state_q == ST_DRIVE);
   assign rsp_valid   = ~fifo_empty;
   assign {rsp_data, rsp_op, rsp_seq} = fifo_rd_data;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state: one command in flight, back to idle once the settle count expires.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (accept)      state_d = ST_DRIVE;
         ST_DRIVE: if (settle_done) state_d = ST_IDLE;
         default:                   state_d = ST_IDLE;
      endcase
   end

   // Operand latch, sequence tagging and settle down-counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_a        <= '0;
         alu_b        <= '0;
         alu_op_sel   <= '0;
         seq_q        <= '0;
         tag_q        <= '0;
         settle_cnt_q <= '0;
      end else if (accept) begin
         alu_a        <= cmd_a;
         alu_b        <= cmd_b;
         alu_op_sel   <= cmd_op;
         tag_q        <= seq_q;
         seq_q        <= seq_q + 1'b1;
         settle_cnt_q <= SETTLE_LOAD;
      end else if ((state_q == ST_DRIVE) && (settle_cnt_q != '0)) begin
         settle_cnt_q <= settle_cnt_q - 1'b1;
      end
   end

   // A push only ever follows an accept that saw room, so the FIFO can't overflow.
   always_ff @(posedge clk) begin
      if (!rst) assert (!(settle_done && (fifo_count == FIFO_FULL)));
   end

   alu_rsp_fifo #(
      .WIDTH (RSP_W),
      .DEPTH (FIFO_DEPTH)
   ) u_rsp_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (settle_done),
      .wr_data ({alu_result, alu_op_sel, tag_q}),
      .pop     (rsp_ready),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

endmodule

// File: tb/tb_alu4bit_cmd_sequencer.sv
// Directed bench for alu4bit_cmd_sequencer with an adder stub standing in for the ALU.
module tb_alu4bit_cmd_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   int         cyc = 0;

   logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
   logic [3:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, rsp_data, rsp_seq;
   logic [2:0] cmd_op, alu_op_sel, rsp_op;

   logic       s3_cmd_valid, s3_cmd_ready, s3_rsp_valid, s3_rsp_ready, s3_busy;
   logic [3:0] s3_cmd_a, s3_cmd_b, s3_alu_a, s3_alu_b, s3_alu_result, s3_rsp_data, s3_rsp_seq;
   logic [2:0] s3_cmd_op, s3_alu_op_sel, s3_rsp_op;

   typedef struct {
      logic [3:0] d;
      logic [2:0] op;
      logic [3:0] seq;
   } exp_t;

   exp_t       exp_q[$];
   logic [3:0] model_seq;
   int         checks = 0;
   int         errors = 0;
   int         sent;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign alu_result    = alu_a + alu_b;
   assign s3_alu_result = s3_alu_a + s3_alu_b;

   alu4bit_cmd_sequencer dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op_sel(alu_op_sel), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_op(rsp_op), .rsp_seq(rsp_seq), .busy(busy)
   );

   alu4bit_cmd_sequencer #(.SETTLE_CYC(3)) dut3 (
      .clk(clk), .rst(rst), .cmd_valid(s3_cmd_valid), .cmd_ready(s3_cmd_ready),
      .cmd_a(s3_cmd_a), .cmd_b(s3_cmd_b), .cmd_op(s3_cmd_op),
      .alu_a(s3_alu_a), .alu_b(s3_alu_b), .alu_op_sel(s3_alu_op_sel), .alu_result(s3_alu_result),
      .rsp_valid(s3_rsp_valid), .rsp_ready(s3_rsp_ready), .rsp_data(s3_rsp_data),
      .rsp_op(s3_rsp_op), .rsp_seq(s3_rsp_seq), .busy(s3_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      cmd_valid = 1'b0;
      step();
      step();
      rst       = 1'b0;
      exp_q.delete();
      model_seq = 4'd0;
      cmd_op    = 3'd0;
   endtask

   // Offers ncmd commands (op increments per accept) and scores responses in order.
   task automatic pump(input int ncmd, input int budget, output int n_sent);
      int   last_cyc;
      logic acc;
      exp_t e;
      n_sent    = 0;
      last_cyc  = 0;
      cmd_valid = (ncmd > 0);
      for (int c = 0; c < budget; c++) begin
         if (n_sent == ncmd && exp_q.size() == 0) break;
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               chk("rsp_spurious", 32'(rsp_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_data", 32'(rsp_data), 32'(e.d));
               chk("rsp_op",   32'(rsp_op),   32'(e.op));
               chk("rsp_seq",  32'(rsp_seq),  32'(e.seq));
            end
         end
         acc = cmd_valid && cmd_ready;
         if (acc) begin
            if (n_sent > 0) chk("accept_spacing", 32'(cyc - last_cyc), 32'd2);
            last_cyc = cyc;
            e.d   = cmd_a + cmd_b;
            e.op  = cmd_op;
            e.seq = model_seq;
            exp_q.push_back(e);
            model_seq = model_seq + 4'd1;
         end
         step();
         if (acc) begin
            n_sent++;
            cmd_op = cmd_op + 3'd1;
            if (n_sent == ncmd) cmd_valid = 1'b0;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_a = 4'd0; cmd_b = 4'd0; cmd_op = 3'd0; rsp_ready = 1'b1;
      s3_cmd_valid = 1'b0; s3_cmd_a = 4'd0; s3_cmd_b = 4'd0; s3_cmd_op = 3'd0; s3_rsp_ready = 1'b1;
      model_seq = 4'd0;

      // 1: reset state, then a single command
      do_reset();
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_alu_a",     32'(alu_a),     32'd0);
      chk("rst_alu_b",     32'(alu_b),     32'd0);
      chk("rst_alu_op",    32'(alu_op_sel), 32'd0);
      cmd_a = 4'd12; cmd_b = 4'd3; cmd_op = 3'd0; cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      chk("t1_drive_ready", 32'(cmd_ready), 32'd0);
      chk("t1_drive_busy",  32'(busy),      32'd1);
      chk("t1_alu_a",       32'(alu_a),     32'd12);
      chk("t1_alu_b",       32'(alu_b),     32'd3);
      chk("t1_no_rsp_yet",  32'(rsp_valid), 32'd0);
      step();
      chk("t1_busy_done",   32'(busy),      32'd0);
      chk("t1_ready_back",  32'(cmd_ready), 32'd1);
      chk("t1_rsp_valid",   32'(rsp_valid), 32'd1);
      chk("t1_rsp_data",    32'(rsp_data),  32'd15);
      chk("t1_rsp_op",      32'(rsp_op),    32'd0);
      chk("t1_rsp_seq",     32'(rsp_seq),   32'd0);
      step();
      chk("t1_rsp_popped",  32'(rsp_valid), 32'd0);

      // 2: eight back-to-back commands, op 0..7
      do_reset();
      cmd_a = 4'd12; cmd_b = 4'd3;
      pump(8, 40, sent);
      chk("t2_sent",    32'(sent),         32'd8);
      chk("t2_drained", 32'(exp_q.size()), 32'd0);

      // 3: consumer stalled, FIFO fills at 4, then drains in order
      do_reset();
      rsp_ready = 1'b0;
      pump(5, 15, sent);
      chk("t3_accepted",     32'(sent),      32'd4);
      chk("t3_ready_low",    32'(cmd_ready), 32'd0);
      chk("t3_head_seq",     32'(rsp_seq),   32'd0);
      step();
      step();
      chk("t3_still_low",    32'(cmd_ready), 32'd0);
      chk("t3_frozen_valid", 32'(rsp_valid), 32'd1);
      chk("t3_frozen_seq",   32'(rsp_seq),   32'd0);
      chk("t3_frozen_op",    32'(rsp_op),    32'd0);
      chk("t3_frozen_data",  32'(rsp_data),  32'd15);
      rsp_ready = 1'b1;
      pump(1, 20, sent);
      chk("t3_fifth_sent",   32'(sent),         32'd1);
      chk("t3_drained",      32'(exp_q.size()), 32'd0);
      chk("t3_next_seq",     32'(model_seq),    32'd5);

      // 4: seq wrap across 17 commands, sum wraps to 0
      do_reset();
      cmd_a = 4'd15; cmd_b = 4'd1;
      pump(17, 80, sent);
      chk("t4_sent",    32'(sent),         32'd17);
      chk("t4_drained", 32'(exp_q.size()), 32'd0);

      // 5: reset mid-DRIVE with two responses queued
      do_reset();
      rsp_ready = 1'b0;
      cmd_a = 4'd12; cmd_b = 4'd3;
      pump(2, 5, sent);
      chk("t5_sent", 32'(sent), 32'd2);
      cmd_valid = 1'b1;
      chk("t5_ready_before", 32'(cmd_ready), 32'd1);
      step();
      cmd_valid = 1'b0;
      chk("t5_in_drive",   32'(busy),      32'd1);
      chk("t5_queued",     32'(rsp_valid), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t5_rsp_valid",  32'(rsp_valid),  32'd0);
      chk("t5_cmd_ready",  32'(cmd_ready),  32'd1);
      chk("t5_busy",       32'(busy),       32'd0);
      chk("t5_alu_a",      32'(alu_a),      32'd0);
      chk("t5_alu_b",      32'(alu_b),      32'd0);
      chk("t5_alu_op",     32'(alu_op_sel), 32'd0);
      exp_q.delete();
      model_seq = 4'd0;
      rsp_ready = 1'b1;
      cmd_a = 4'd1; cmd_b = 4'd2; cmd_op = 3'd5;
      pump(1, 10, sent);
      chk("t5_post_sent",    32'(sent),         32'd1);
      chk("t5_post_drained", 32'(exp_q.size()), 32'd0);

      // 6: SETTLE_CYC=3 instance, one command
      s3_cmd_a = 4'd2; s3_cmd_b = 4'd5; s3_cmd_op = 3'd3; s3_cmd_valid = 1'b1;
      chk("t6_ready_idle", 32'(s3_cmd_ready), 32'd1);
      step();
      s3_cmd_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("t6_busy",      32'(s3_busy),      32'd1);
         chk("t6_ready_low", 32'(s3_cmd_ready), 32'd0);
         chk("t6_no_rsp",    32'(s3_rsp_valid), 32'd0);
         step();
      end
      chk("t6_busy_done",  32'(s3_busy),      32'd0);
      chk("t6_rsp_valid",  32'(s3_rsp_valid), 32'd1);
      chk("t6_rsp_data",   32'(s3_rsp_data),  32'd7);
      chk("t6_rsp_op",     32'(s3_rsp_op),    32'd3);
      chk("t6_rsp_seq",    32'(s3_rsp_seq),   32'd0);
      chk("t6_ready_back", 32'(s3_cmd_ready), 32'd1);
      step();
      chk("t6_popped",     32'(s3_rsp_valid), 32'd0);
      chk("t6_alu_a_hold", 32'(s3_alu_a),     32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
